// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the multi-lane round-robin bus arbiter.
// Helpers work on fixed maximum-width vectors so any lane configuration can share them.
package bus_arb_pkg;

  localparam int PKT_MAX = 256;
  localparam int ID_MAX  = 32;
  localparam int DRV_MAX = 64;
  localparam int IDX_W   = 6;

  typedef enum logic {
    IDLE,
    DELIVER
  } lane_state_e;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } pick_t;

  // Destination field is the top dst_w bits of a pkt_w-bit packet; upper bits return zero.
  function automatic logic [ID_MAX-1:0] get_dest(input logic [PKT_MAX-1:0] pkt,
                                                 input int pkt_w, input int dst_w);
    logic [PKT_MAX-1:0] shifted;
    logic [ID_MAX-1:0]  dest;
    shifted = pkt >> (pkt_w - dst_w);
    dest    = '0;
    for (int i = 0; i < ID_MAX; i++) begin
      if (i < dst_w) dest[i] = shifted[i];
    end
    return dest;
  endfunction

  // First pending index searching upward from last+1, wrapping modulo n.
  function automatic pick_t rr_pick(input logic [DRV_MAX-1:0] pend, input int last,
                                    input int n);
    pick_t p;
    int    idx;
    p.valid = 1'b0;
    p.idx   = '0;
    for (int k = DRV_MAX; k >= 1; k--) begin
      if (k <= n) begin
        idx = last + k;
        if (idx >= n) idx = idx - n;
        if (pend[idx]) begin
          p.valid = 1'b1;
          p.idx   = IDX_W'(idx);
        end
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/bus_arb_lane.sv
// One bus lane: round-robin pick of a pending device, one-cycle pop, then a
// one-cycle push to the addressed device(s) or a saturating drop count.
module bus_arb_lane
  import bus_arb_pkg::*;
#(
  parameter int                drvrs     = 4,
  parameter int                pckg_sz   = 16,
  parameter int                id_w      = 8,
  parameter logic [id_w-1:0]   broadcast = 8'hFF,
  parameter int                cnt_w     = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [drvrs-1:0]                  pndng,
  input  logic [drvrs-1:0][pckg_sz-1:0]     D_pop,
  output logic [drvrs-1:0]                  pop,
  output logic [drvrs-1:0]                  push,
  output logic [drvrs-1:0][pckg_sz-1:0]     D_push,
  output logic [cnt_w-1:0]                  drop_cnt,
  output logic                              busy
);

  localparam int IW = (drvrs > 1) ? $clog2(drvrs) : 1;

  lane_state_e        r_state;
  logic [IW-1:0]      r_last;   // last winner, which is also the sender during DELIVER
  logic [pckg_sz-1:0] r_pkt;
  logic [drvrs-1:0]   r_pop;
  logic [drvrs-1:0]   r_push;
  logic [cnt_w-1:0]   r_drop;

  lane_state_e        w_state_nxt;
  pick_t              w_pick;
  logic               w_take;
  logic [drvrs-1:0]   w_pop_nxt;
  logic [drvrs-1:0]   w_push_nxt;
  logic [pckg_sz-1:0] w_pkt_nxt;
  logic               w_drop_inc;
  logic [ID_MAX-1:0]  w_dest;
  logic               w_is_bcast;
  int                 w_dest_int;

  assign w_pick     = rr_pick(DRV_MAX'(pndng), int'(r_last), drvrs);
  assign w_take     = (r_state == IDLE) && w_pick.valid;
  assign w_dest     = get_dest(PKT_MAX'(r_pkt), pckg_sz, id_w);
  assign w_is_bcast = (w_dest == ID_MAX'(broadcast));
  assign w_dest_int = int'(w_dest);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    w_state_nxt = r_state;
    w_pop_nxt   = '0;
    w_push_nxt  = '0;
    w_pkt_nxt   = r_pkt;
    w_drop_inc  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_pick.valid) begin
          w_state_nxt = DELIVER;
          for (int j = 0; j < drvrs; j++) begin
            if (j == int'(w_pick.idx)) begin
              w_pop_nxt[j] = 1'b1;
              w_pkt_nxt    = D_pop[j];
            end
          end
        end
      end
      DELIVER: begin
        w_state_nxt = IDLE;
        if (w_is_bcast) begin
          for (int j = 0; j < drvrs; j++) begin
            if (j != int'(r_last)) w_push_nxt[j] = 1'b1;
          end
        end else if (w_dest_int < drvrs) begin
          for (int j = 0; j < drvrs; j++) begin
            if (j == w_dest_int) w_push_nxt[j] = 1'b1;
          end
        end else begin
          w_drop_inc = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: r_pkt is a plain register feeding D_push, which must read zero after reset, so it is reset.
      r_state <= IDLE;
      r_last  <= IW'(drvrs - 1);
      r_pkt   <= '0;
      r_pop   <= '0;
      r_push  <= '0;
      r_drop  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_state <= w_state_nxt;
      r_pop   <= w_pop_nxt;
      r_push  <= w_push_nxt;
      if (w_take) begin
        r_pkt  <= w_pkt_nxt;
        r_last <= IW'(w_pick.idx);
      end
      if (w_drop_inc && (r_drop != '1)) r_drop <= r_drop + cnt_w'(1);
    end
  end

  assign pop      = r_pop;
  assign push     = r_push;
  assign D_push   = {drvrs{r_pkt}};
  assign drop_cnt = r_drop;
  assign busy     = (r_state == DELIVER);

endmodule

// File: rtl/bus_rr_arbiter.sv
// Multi-bus arbiter/router: `bits` fully independent lanes, each with its own
// round-robin pointer; this level is wiring only.
module bus_rr_arbiter
  import bus_arb_pkg::*;
#(
  parameter int              bits      = 1,
  parameter int              drvrs     = 4,
  parameter int              pckg_sz   = 16,
  parameter int              id_w      = 8,
  parameter logic [id_w-1:0] broadcast = 8'hFF,
  parameter int              cnt_w     = 16
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [bits-1:0][drvrs-1:0]               pndng,
  input  logic [bits-1:0][drvrs-1:0][pckg_sz-1:0]  D_pop,
  output logic [bits-1:0][drvrs-1:0]               pop,
  output logic [bits-1:0][drvrs-1:0]               push,
  output logic [bits-1:0][drvrs-1:0][pckg_sz-1:0]  D_push,
  output logic [bits-1:0][cnt_w-1:0]               drop_cnt,
  output logic [bits-1:0]                          busy
);

  for (genvar b = 0; b < bits; b++) begin : g_lane
    bus_arb_lane #(
      .drvrs    (drvrs),
      .pckg_sz  (pckg_sz),
      .id_w     (id_w),
      .broadcast(broadcast),
      .cnt_w    (cnt_w)
    ) u_lane (
      .clk     (clk),
      .reset   (reset),
      .pndng   (pndng[b]),
      .D_pop   (D_pop[b]),
      .pop     (pop[b]),
      .push    (push[b]),
      .D_push  (D_push[b]),
      .drop_cnt(drop_cnt[b]),
      .busy    (busy[b])
    );
  end

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic checked
// against a queue-based device/round-robin reference model.
module tb_bus_rr_arbiter;

  localparam int BITS = 2;
  localparam int DRV  = 4;
  localparam int PW   = 16;
  localparam int CW   = 16;
  localparam int SCW  = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  logic [BITS-1:0][DRV-1:0]         pndng, pop, push;
  logic [BITS-1:0][DRV-1:0][PW-1:0] d_pop, d_push;
  logic [BITS-1:0][CW-1:0]          drop_cnt;
  logic [BITS-1:0]                  busy;

  logic [0:0][0:0]         s_pndng, s_pop, s_push;
  logic [0:0][0:0][PW-1:0] s_d_pop, s_d_push;
  logic [0:0][SCW-1:0]     s_drop;
  logic [0:0]              s_busy;

  int total = 0;
  int bad   = 0;

  logic [PW-1:0] q [BITS][DRV][$];

  bus_rr_arbiter #(.bits(BITS), .drvrs(DRV), .pckg_sz(PW), .id_w(8),
                   .broadcast(8'hFF), .cnt_w(CW)) dut (
    .clk(clk), .reset(reset), .pndng(pndng), .D_pop(d_pop), .pop(pop),
    .push(push), .D_push(d_push), .drop_cnt(drop_cnt), .busy(busy));

  bus_rr_arbiter #(.bits(1), .drvrs(1), .pckg_sz(PW), .id_w(8),
                   .broadcast(8'hFF), .cnt_w(SCW)) dut_small (
    .clk(clk), .reset(reset), .pndng(s_pndng), .D_pop(s_d_pop), .pop(s_pop),
    .push(s_push), .D_push(s_d_push), .drop_cnt(s_drop), .busy(s_busy));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    pndng   = '0;
    d_pop   = '0;
    s_pndng = '0;
    s_d_pop = '0;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  function automatic logic [PW-1:0] rand_pkt();
    int r = $urandom_range(0, 9);
    logic [7:0] d;
    if (r < 7)      d = 8'(r % 4);
    else if (r < 9) d = 8'hFF;
    else            d = 8'($urandom_range(4, 254));
    return {d, 8'($urandom)};
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    pndng = '1;
    d_pop = '0;
    s_pndng = '1;
    s_d_pop = '0;
    repeat (2) tick();
    total++; if (pop !== '0) begin bad++; $display("FAIL reset_pop got=%h exp=0", pop); end
    total++; if (push !== '0) begin bad++; $display("FAIL reset_push got=%h exp=0", push); end
    total++; if (d_push !== '0) begin bad++; $display("FAIL reset_dpush got=%h exp=0", d_push); end
    total++; if (drop_cnt !== '0) begin bad++; $display("FAIL reset_drop got=%h exp=0", drop_cnt); end
    total++; if (busy !== '0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (s_drop !== '0) begin bad++; $display("FAIL reset_small_drop got=%h exp=0", s_drop); end
    pndng   = '0;
    s_pndng = '0;
    reset   = 1'b0;
    tick();
    total++; if (pop !== '0 || busy !== '0) begin bad++; $display("FAIL idle_no_pend got pop=%h busy=%b exp=0", pop, busy); end
  endtask

  task automatic test_first_grant();
    do_reset();
    pndng[0][2] = 1'b1;
    d_pop[0][2] = 16'h0155;
    tick();
    total++; if (pop[0] !== 4'b0100) begin bad++; $display("FAIL first_pop got=%b exp=0100", pop[0]); end
    total++; if (busy[0] !== 1'b1) begin bad++; $display("FAIL first_busy got=%b exp=1", busy[0]); end
    pndng[0][2] = 1'b0;
    tick();
    total++; if (push[0] !== 4'b0010) begin bad++; $display("FAIL first_push got=%b exp=0010", push[0]); end
    total++; if (pop[0] !== 4'b0000) begin bad++; $display("FAIL first_no_pop got=%b exp=0000", pop[0]); end
    total++; if (d_push[0] !== {4{16'h0155}}) begin bad++; $display("FAIL first_dpush got=%h exp=%h", d_push[0], {4{16'h0155}}); end
  endtask

  task automatic test_rr_order();
    int w;
    do_reset();
    for (int i = 0; i < DRV; i++) begin
      pndng[0][i] = 1'b1;
      d_pop[0][i] = {8'((i + 1) % 4), 8'(i)};
    end
    for (int k = 0; k < 5; k++) begin
      w = k % 4;
      tick();
      total++; if (pop[0] !== 4'(1 << w)) begin bad++; $display("FAIL rr_pop[%0d] got=%b exp=%b", k, pop[0], 4'(1 << w)); end
      tick();
      total++; if (pop[0] !== 4'b0000 || push[0] !== 4'(1 << ((w + 1) % 4))) begin
        bad++; $display("FAIL rr_push[%0d] got pop=%b push=%b exp pop=0000 push=%b", k, pop[0], push[0], 4'(1 << ((w + 1) % 4)));
      end
    end
    pndng = '0;
  endtask

  task automatic test_broadcast();
    do_reset();
    pndng[0][1] = 1'b1;
    d_pop[0][1] = 16'hFF3C;
    tick();
    total++; if (pop[0] !== 4'b0010) begin bad++; $display("FAIL bcast_pop got=%b exp=0010", pop[0]); end
    pndng = '0;
    tick();
    total++; if (push[0] !== 4'b1101) begin bad++; $display("FAIL bcast_push got=%b exp=1101", push[0]); end
    total++; if (drop_cnt[0] !== 16'd0) begin bad++; $display("FAIL bcast_drop got=%0d exp=0", drop_cnt[0]); end
  endtask

  task automatic test_drop();
    int exp;
    do_reset();
    pndng[0][0] = 1'b1;
    d_pop[0][0] = 16'h073C;
    tick();
    pndng = '0;
    tick();
    total++; if (push[0] !== 4'b0000) begin bad++; $display("FAIL drop_push got=%b exp=0000", push[0]); end
    total++; if (drop_cnt[0] !== 16'd1) begin bad++; $display("FAIL drop_cnt got=%0d exp=1", drop_cnt[0]); end
    // single-device lane: broadcast is neither pushed nor counted
    s_pndng = '1;
    s_d_pop = 16'hFF00;
    tick();
    total++; if (s_pop !== 1'b1) begin bad++; $display("FAIL small_bcast_pop got=%b exp=1", s_pop); end
    s_d_pop = 16'h073C;
    tick();
    total++; if (s_push !== 1'b0 || s_drop !== 4'd0) begin bad++; $display("FAIL small_bcast got push=%b drop=%0d exp push=0 drop=0", s_push, s_drop); end
    for (int k = 1; k <= 18; k++) begin
      exp = (k > 15) ? 15 : k;
      tick();
      total++; if (s_pop !== 1'b1) begin bad++; $display("FAIL sat_pop[%0d] got=%b exp=1", k, s_pop); end
      tick();
      total++; if (s_drop !== 4'(exp) || s_push !== 1'b0) begin bad++; $display("FAIL sat_drop[%0d] got drop=%0d push=%b exp drop=%0d push=0", k, s_drop, s_push, exp); end
    end
    s_pndng = '0;
  endtask

  task automatic test_lanes_parallel();
    do_reset();
    pndng[0][3] = 1'b1;
    d_pop[0][3] = 16'h02AA;
    pndng[1][0] = 1'b1;
    d_pop[1][0] = 16'hFF55;
    tick();
    total++; if (pop !== {4'b0001, 4'b1000}) begin bad++; $display("FAIL lanes_pop got=%h exp=%h", pop, {4'b0001, 4'b1000}); end
    pndng = '0;
    tick();
    total++; if (push !== {4'b1110, 4'b0100}) begin bad++; $display("FAIL lanes_push got=%h exp=%h", push, {4'b1110, 4'b0100}); end
    total++; if (d_push !== {{4{16'hFF55}}, {4{16'h02AA}}}) begin bad++; $display("FAIL lanes_dpush got=%h exp=%h", d_push, {{4{16'hFF55}}, {4{16'h02AA}}}); end
    total++; if (drop_cnt !== '0) begin bad++; $display("FAIL lanes_drop got=%h exp=0", drop_cnt); end
  endtask

  task automatic test_reset_in_deliver();
    do_reset();
    pndng[0][2] = 1'b1;
    d_pop[0][2] = 16'h0011;
    tick();
    total++; if (busy[0] !== 1'b1) begin bad++; $display("FAIL rid_busy_before got=%b exp=1", busy[0]); end
    reset = 1'b1;
    for (int i = 0; i < DRV; i++) begin
      pndng[0][i] = 1'b1;
      d_pop[0][i] = 16'h0100;
    end
    tick();
    total++; if (push[0] !== 4'b0000 || busy[0] !== 1'b0 || pop[0] !== 4'b0000) begin
      bad++; $display("FAIL rid_after got push=%b busy=%b pop=%b exp all 0", push[0], busy[0], pop[0]);
    end
    reset = 1'b0;
    tick();
    total++; if (pop[0] !== 4'b0001) begin bad++; $display("FAIL rid_next_grant got=%b exp=0001", pop[0]); end
    pndng = '0;
    tick();
  endtask

  task automatic test_random(input int cycles);
    logic [DRV-1:0] pend_prev [BITS];
    bit             prev_pop  [BITS];
    int             last      [BITS];
    logic [DRV-1:0] exp_mask  [BITS];
    logic [PW-1:0]  exp_pkt   [BITS];
    int             exp_drop  [BITS];
    int             w;
    logic [7:0]     dest;
    do_reset();
    for (int b = 0; b < BITS; b++) begin
      pend_prev[b] = '0;
      prev_pop[b]  = 1'b0;
      last[b]      = DRV - 1;
      exp_mask[b]  = '0;
      exp_pkt[b]   = '0;
      exp_drop[b]  = 0;
      for (int i = 0; i < DRV; i++) q[b][i].delete();
    end
    for (int c = 0; c < cycles; c++) begin
      tick();
      for (int b = 0; b < BITS; b++) begin
        if (prev_pop[b]) begin
          total++; if (pop[b] !== '0 || push[b] !== exp_mask[b]) begin
            bad++; $display("FAIL rand_deliver c=%0d lane=%0d got pop=%b push=%b exp pop=0000 push=%b", c, b, pop[b], push[b], exp_mask[b]);
          end
          total++; if (d_push[b] !== {DRV{exp_pkt[b]}}) begin bad++; $display("FAIL rand_dpush c=%0d lane=%0d got=%h exp=%h", c, b, d_push[b], {DRV{exp_pkt[b]}}); end
          total++; if (drop_cnt[b] !== CW'(exp_drop[b])) begin bad++; $display("FAIL rand_drop c=%0d lane=%0d got=%0d exp=%0d", c, b, drop_cnt[b], exp_drop[b]); end
          prev_pop[b] = 1'b0;
        end else if (pend_prev[b] != '0) begin
          w = -1;
          for (int k = 1; k <= DRV; k++) begin
            if (w < 0 && pend_prev[b][(last[b] + k) % DRV]) w = (last[b] + k) % DRV;
          end
          total++; if (pop[b] !== DRV'(1 << w) || busy[b] !== 1'b1 || push[b] !== '0) begin
            bad++; $display("FAIL rand_grant c=%0d lane=%0d got pop=%b busy=%b push=%b exp pop=%b busy=1 push=0000", c, b, pop[b], busy[b], push[b], DRV'(1 << w));
          end
          exp_pkt[b] = q[b][w].pop_front();
          last[b]    = w;
          dest       = exp_pkt[b][PW-1 -: 8];
          if (dest == 8'hFF)        exp_mask[b] = ~DRV'(1 << w);
          else if (int'(dest) < DRV) exp_mask[b] = DRV'(1 << int'(dest));
          else begin
            exp_mask[b] = '0;
            exp_drop[b]++;
          end
          prev_pop[b] = 1'b1;
        end else begin
          total++; if (pop[b] !== '0 || push[b] !== '0 || busy[b] !== 1'b0) begin
            bad++; $display("FAIL rand_idle c=%0d lane=%0d got pop=%b push=%b busy=%b exp all 0", c, b, pop[b], push[b], busy[b]);
          end
        end
      end
      for (int b = 0; b < BITS; b++) begin
        for (int i = 0; i < DRV; i++) begin
          if (q[b][i].size() < 3 && $urandom_range(0, 3) == 0) q[b][i].push_back(rand_pkt());
          pndng[b][i] = (q[b][i].size() != 0);
          d_pop[b][i] = (q[b][i].size() != 0) ? q[b][i][0] : '0;
        end
        pend_prev[b] = pndng[b];
      end
    end
    pndng = '0;
    tick();
    tick();
  endtask

  initial begin
    pndng   = '0;
    d_pop   = '0;
    s_pndng = '0;
    s_d_pop = '0;
    test_reset();
    test_first_grant();
    test_rr_order();
    test_broadcast();
    test_drop();
    test_lanes_parallel();
    test_reset_in_deliver();
    test_random(800);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bus_rr_arbiter.md
# bus_rr_arbiter

Synthesizable multi-bus arbiter and packet router for the device bus, driven through the `bus_if` interface by the per-device FIFO drivers. It generalises the single-bus arbiter to `bits` independent buses, each with its own round-robin grant pointer. Each bus pops one packet from a pending device and pushes it to the addressed device, or to every other device for broadcast. Packets to non-existent destinations are dropped and counted.

## Interface
Parameters:
- `bits`, 1: number of independent buses (lanes).
- `drvrs`, 4: devices per bus.
- `pckg_sz`, 16: packet width in bits.
- `broadcast`, 8'hFF: destination ID meaning "all devices except sender".
- `id_w`, 8: destination field width, taken from `D_pop[pckg_sz-1 -: id_w]`.
- `cnt_w`, 16: drop-counter width.

Ports:
- `clk`  in  1: single clock, all logic on rising edge.
- `reset`  in  1: synchronous, active-high.
- `pndng`  in  [bits][drvrs]: device FIFO non-empty.
- `D_pop`  in  [bits][drvrs][pckg_sz]: head-of-FIFO data, show-ahead, valid while `pndng`.
- `pop`  out  [bits][drvrs]: one-cycle dequeue strobe.
- `push`  out  [bits][drvrs]: one-cycle enqueue strobe to destination.
- `D_push`  out  [bits][drvrs][pckg_sz]: packet presented to all devices of the lane.
- `drop_cnt`  out  [bits][cnt_w]: invalid-destination packets per lane.
- `busy`  out  [bits]: lane is in DELIVER.

## Operation
- Lanes are fully independent and need no cross-lane arbitration.
- Per-lane FSM:
  - IDLE: if any `pndng[b][i]`, pick winner w = first pending index searching from `last+1` modulo `drvrs`. Assert `pop[b][w]` this cycle, latch `D_pop[b][w]` and sender w, set `last=w`, go to DELIVER. If nothing is pending, stay in IDLE.
  - DELIVER: let dest be the latched destination field.
    - dest == `broadcast`: `push[b][j]=1` for all j != sender.
    - dest < `drvrs`: `push[b][dest]=1`, including dest == sender (loopback allowed).
    - Otherwise: no push; `drop_cnt[b]` += 1, saturating at all-ones.
    - Always return to IDLE.
- `D_push[b][j]` = latched packet for every j. It holds its value outside DELIVER.
- `pop` and `push` are registered outputs; at most one `pop` bit is set per lane per cycle.

## Timing
- Reset values: `pop`=0, `push`=0, `D_push`=0, `drop_cnt`=0, `busy`=0, state=IDLE, `last`=`drvrs-1` (device 0 wins first).
- Latency: `pop` in cycle N, `push` in cycle N+1, earliest next `pop` on that lane in cycle N+2. Peak throughput is one packet per 2 cycles per lane.
- `pndng` dropping while in DELIVER has no effect. `pndng` is only sampled in IDLE.
- Reset asserted during DELIVER: the next cycle has no `push`, the packet is discarded, and the pointer and counters are re-initialised.
- `drvrs`=1: a broadcast produces no push and is not counted as a drop.

## Structure
- Package `bus_arb_pkg`:
  - `lane_state_e` enum {IDLE, DELIVER}.
  - Function `get_dest(pkt)` returning the top `id_w` bits.
  - Function `rr_pick(pend, last)`.
- Sub-module `bus_arb_lane`: one lane (FSM, pointer, latch, counter). It is instantiated `bits` times in a generate loop. The top level contains only wiring.

## Test plan
- Reset, then `pndng[0][2]=1`, `D_pop[0][2]=16'h0155` → `pop[0][2]` at the first IDLE edge after reset; next cycle `push[0][1]=1` only, `D_push=16'h0155`.
- All 4 devices pending continuously with valid dests → grant order 0,1,2,3,0 with `pop` every 2 cycles; no device is granted twice before all are granted.
- Broadcast: device 1 sends `16'hFF3C` → `push[0]=4'b1101`, `drop_cnt`=0.
- Invalid dest `16'h073C` with `drvrs`=4 → no push, `drop_cnt[0]`=1. After `2**cnt_w` more such packets, the counter stays at all-ones.
- `bits`=2: lane 0 and lane 1 pending simultaneously → both `pop` in the same cycle, both `push` the next cycle, with no interference.
- Assert `reset` in the DELIVER cycle → no `push` follows, `busy`=0, and the next grant goes to device 0.
